sseg_scan_ctrl: RTL

Time-multiplexed scan controller for the 4-digit, common-anode seven-segment display. It owns the digit-select sequencing, refresh divider, hex-to-segment decode and tear-free value loading. Upstream logic loads a 16-bit hex value over a valid/ready handshake, and the block drives the display pins directly.

---
 rtl/sseg_scan_ctrl_if.sv | 11 +
 rtl/sseg_scan_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/sseg_scan_ctrl_if.sv
// Load channel into the seven-segment scan controller: one 16-bit hex value
// plus per-digit decimal points, transferred on valid && ready.
interface sseg_scan_ctrl_if;
  logic        valid;
  logic        ready;
  logic [15:0] data;
  logic [3:0]  dp;

  modport master (output valid, data, dp, input ready);
  modport slave  (input valid, data, dp, output ready);
endinterface

// File: rtl/sseg_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller with a one-entry
// shadow register so new values are only committed at frame boundaries.
module sseg_scan_ctrl #(
  parameter int DIV      = 50000,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  sseg_scan_ctrl_if.slave    ld,
  input  logic               en,
  output logic [6:0]         seg,
  output logic               dp,
  output logic [3:0]         an,
  output logic               frame
);

  localparam int unsigned   CW      = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   disp_val;
  logic [3:0]    disp_dp;
  logic [15:0]   pend_val;
  logic [3:0]    pend_dp;
  logic          pend_full;
  logic          frame_q;

  logic          tick;
  logic          frame_end;
  logic          xfer;
  logic [3:0]    nib;
  logic [15:0]   upper;
  logic          blank;
  logic [3:0]    an_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign ld.ready = !pend_full;

  always_comb begin
    tick      = (cnt == CNT_MAX);
    frame_end = tick && (idx == 2'd3);
    xfer      = ld.valid && !pend_full;
    nib       = disp_val[{idx, 2'b00} +: 4];
    // Leading-zero test: everything from the current digit upward is zero.
    upper     = disp_val >> {idx, 2'b00};
    blank     = BLANK_LZ && (idx != 2'd0) && (upper == '0);
    an_nxt    = '1;
    if (en && !blank) an_nxt[idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      disp_val  <= '0;
      disp_dp   <= '0;
      pend_val  <= '0;
      pend_dp   <= '0;
      pend_full <= 1'b0;
      frame_q   <= 1'b0;
      seg       <= '1;
      dp        <= 1'b1;
      an        <= '1;
      frame     <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) idx <= idx + 2'd1;

      // A transfer can only happen with pending empty, so it never races a commit.
      if (xfer) begin
        pend_val  <= ld.data;
        pend_dp   <= ld.dp;
        pend_full <= 1'b1;
      end else if (frame_end && pend_full) begin
        disp_val  <= pend_val;
        disp_dp   <= pend_dp;
        pend_full <= 1'b0;
      end

      seg     <= hex7(nib);
      dp      <= !disp_dp[idx];
      an      <= an_nxt;
      // Extra stage lines FRAME up with the first segment pattern of the new frame.
      frame_q <= frame_end;
      frame   <= frame_q;
    end
  end

endmodule
